ip4_rtl_axis_wcq: RTL and testbench

IP4_RTL_AXIS_WCQ -- requirements
Module: ip4_rtl_axis_wcq

---
 rtl/ip4_rtl_pkg.sv | 15 +
 rtl/ip4_rtl_axis_wcq_if.sv | 55 +++++
 rtl/ip4_rtl_fifo.sv | 64 ++++++
 rtl/ip4_rtl_axis_wcq.sv | 153 +++++++++++++++
 tb/tb_ip4_rtl_axis_wcq.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ip4_rtl_pkg.sv
// Shared types and encodings for the IP4 write-collector blocks.
package ip4_rtl_pkg;

  // Control FSM states of the AXI write collector.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } wcq_state_e;

  // AXI BRESP encodings.
  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;

endpackage

// File: rtl/ip4_rtl_axis_wcq_if.sv
// AXI write channels (AW/W/B) plus the beat stream toward the core.
// The slave modport is the collector's view; the master modport is the
// view of whatever drives the bursts and consumes the beats.
interface ip4_rtl_axis_wcq_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4
);
  logic                  awvalid;
  logic                  awready;
  logic [ID_W-1:0]       awid;
  logic [ADDR_W-1:0]     awaddr;
  logic [3:0]            awlen;

  logic                  wvalid;
  logic                  wready;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic                  wlast;

  logic                  bvalid;
  logic                  bready;
  logic [ID_W-1:0]       bid;
  logic [1:0]            bresp;

  logic                  cvalid;
  logic                  cready;
  logic [ADDR_W-1:0]     caddr;
  logic [DATA_W-1:0]     cdata;
  logic [DATA_W/8-1:0]   cstrb;
  logic                  clast;

  modport slave (
    input  awvalid, awid, awaddr, awlen,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bid, bresp,
    input  bready,
    output cvalid, caddr, cdata, cstrb, clast,
    input  cready
  );

  modport master (
    output awvalid, awid, awaddr, awlen,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bid, bresp,
    output bready,
    input  cvalid, caddr, cdata, cstrb, clast,
    output cready
  );

endinterface

// File: rtl/ip4_rtl_fifo.sv
// Synchronous FIFO with occupancy count. Push is refused when full and pop
// when empty; a simultaneous accepted push and pop leaves the count unchanged.
module ip4_rtl_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  output logic                   full,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == DEPTH_C);
  assign empty     = (count_r == '0);
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;
  assign dout      = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Pointer and occupancy bookkeeping; reset empties the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents are only meaningful below the count.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

endmodule

// File: rtl/ip4_rtl_axis_wcq.sv
// AXI write-burst collector: accepts one INCR burst at a time, splits it
// into addressed beats queued toward the core, and answers with a B
// response once the counted burst length has been received. The response
// does not wait for queued beats to drain.
module ip4_rtl_axis_wcq
  import ip4_rtl_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4,
  parameter int DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ip4_rtl_axis_wcq_if.slave      bus,
  output logic [$clog2(DEPTH):0] fill_lvl
);
  localparam int STRB_W  = DATA_W / 8;
  localparam int BYTE_SH = $clog2(STRB_W);
  localparam int FIFO_W  = ADDR_W + DATA_W + STRB_W + 1;
  localparam logic [3:0] BEAT_ONE = 4'd1;

  // Beat address: base plus beat index times bytes per beat, wrapping.
  function automatic logic [ADDR_W-1:0] beat_addr(
    input logic [ADDR_W-1:0] base,
    input logic [3:0]        idx
  );
    return base + (ADDR_W'(idx) << BYTE_SH);
  endfunction

  wcq_state_e          state_r;
  logic                awready_r;
  logic                bvalid_r;
  logic [ID_W-1:0]     bid_r;
  logic [1:0]          bresp_r;
  logic [ID_W-1:0]     id_r;
  logic [ADDR_W-1:0]   base_r;
  logic [3:0]          len_r;
  logic [3:0]          cnt_r;
  logic                err_r;

  logic                wready_s;
  logic                w_hs_s;
  logic                last_s;
  logic                last_err_s;
  logic                fifo_full_s;
  logic                fifo_empty_s;
  logic                pop_s;
  logic [FIFO_W-1:0]   push_data_s;
  logic [FIFO_W-1:0]   head_s;

  // wready looks only at the registered count, never at a same-cycle pop.
  assign wready_s    = (state_r == ST_DATA) && !fifo_full_s;
  assign w_hs_s      = bus.wvalid && wready_s;
  assign last_s      = (cnt_r == len_r);
  assign last_err_s  = (bus.wlast != last_s);
  assign push_data_s = {beat_addr(base_r, cnt_r), bus.wdata, bus.wstrb, last_s};
  assign pop_s       = !fifo_empty_s && bus.cready;

  assign bus.awready = awready_r;
  assign bus.wready  = wready_s;
  assign bus.bvalid  = bvalid_r;
  assign bus.bid     = bid_r;
  assign bus.bresp   = bresp_r;
  assign bus.cvalid  = !fifo_empty_s;

  // Control FSM: burst capture, beat counting, error tracking and B response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      awready_r <= 1'b1;
      bvalid_r  <= 1'b0;
      bid_r     <= '0;
      bresp_r   <= BRESP_OKAY;
      id_r      <= '0;
      base_r    <= '0;
      len_r     <= 4'd0;
      cnt_r     <= 4'd0;
      err_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.awvalid && awready_r) begin
            id_r      <= bus.awid;
            base_r    <= bus.awaddr;
            len_r     <= bus.awlen;
            cnt_r     <= 4'd0;
            err_r     <= 1'b0;
            awready_r <= 1'b0;
            state_r   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_hs_s) begin
            cnt_r <= cnt_r + BEAT_ONE;
            if (last_err_s) begin
              err_r <= 1'b1;
            end
            if (last_s) begin
              state_r  <= ST_RESP;
              bvalid_r <= 1'b1;
              bid_r    <= id_r;
              bresp_r  <= (err_r || last_err_s) ? BRESP_SLVERR : BRESP_OKAY;
            end
          end
        end
        ST_RESP: begin
          if (bus.bready) begin
            state_r   <= ST_IDLE;
            bvalid_r  <= 1'b0;
            bid_r     <= '0;
            bresp_r   <= BRESP_OKAY;
            awready_r <= 1'b1;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          awready_r <= 1'b1;
          bvalid_r  <= 1'b0;
        end
      endcase
    end
  end

  ip4_rtl_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_hs_s),
    .din   (push_data_s),
    .full  (fifo_full_s),
    .pop   (pop_s),
    .dout  (head_s),
    .empty (fifo_empty_s),
    .count (fill_lvl)
  );

  // Present the head beat, forcing zeros while the queue is empty.
  always_comb begin
    bus.caddr = '0;
    bus.cdata = '0;
    bus.cstrb = '0;
    bus.clast = 1'b0;
    if (!fifo_empty_s) begin
      {bus.caddr, bus.cdata, bus.cstrb, bus.clast} = head_s;
    end else begin
      bus.clast = 1'b0;
    end
  end

endmodule

// File: tb/tb_ip4_rtl_axis_wcq.sv
// Self-checking bench for ip4_rtl_axis_wcq: directed scenarios followed by
// randomized bursts, compared against a beat-list model of the bursts.
module tb_ip4_rtl_axis_wcq;
  import ip4_rtl_pkg::*;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 32;
  localparam int ID_W   = 4;
  localparam int DEPTH  = 8;
  localparam int STRB_W = DATA_W / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [$clog2(DEPTH):0] fill_lvl;

  ip4_rtl_axis_wcq_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W)) bus ();

  ip4_rtl_axis_wcq #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .ID_W   (ID_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .fill_lvl (fill_lvl)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
    logic              last;
  } beat_t;

  beat_t             exp_q[$];
  int                checks = 0;
  int                errors = 0;
  int                cready_mode = 1;
  int                delivered = 0;
  logic [ID_W-1:0]   cur_id;
  logic [ADDR_W-1:0] cur_base;
  int                cur_len;
  int                cur_idx;
  bit                cur_err;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Consumer: owns cready and checks every popped beat against the model.
  initial begin
    beat_t e;
    bus.cready = 1'b0;
    forever begin
      @(negedge clk);
      case (cready_mode)
        0:       bus.cready = 1'b0;
        1:       bus.cready = 1'b1;
        default: bus.cready = 1'($urandom_range(0, 1));
      endcase
      if (rst_n && bus.cvalid && bus.cready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'(bus.caddr), 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          check("caddr", 64'(bus.caddr), 64'(e.addr));
          check("cdata", 64'(bus.cdata), 64'(e.data));
          check("cstrb", 64'(bus.cstrb), 64'(e.strb));
          check("clast", 64'(bus.clast), 64'(e.last));
          delivered++;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_aw(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr, input int len);
    int n;
    n = 0;
    bus.awvalid = 1'b1;
    bus.awid    = id;
    bus.awaddr  = addr;
    bus.awlen   = 4'(len);
    while (!bus.awready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("aw_accept", 64'(bus.awready), 64'd1);
    @(negedge clk);
    bus.awvalid = 1'b0;
    bus.awid    = ID_W'($urandom);
    bus.awaddr  = ADDR_W'($urandom);
    check("awready_in_data", 64'(bus.awready), 64'd0);
    cur_id   = id;
    cur_base = addr;
    cur_len  = len;
    cur_idx  = 0;
    cur_err  = 1'b0;
  endtask

  task automatic send_beat(input logic lastbit);
    int n;
    beat_t b;
    n = 0;
    bus.wdata  = {$urandom, $urandom};
    bus.wstrb  = STRB_W'($urandom);
    bus.wlast  = lastbit;
    bus.wvalid = 1'b1;
    while (!bus.wready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("w_accept", 64'(bus.wready), 64'd1);
    if (bus.wready) begin
      b.addr = cur_base + ADDR_W'(cur_idx * STRB_W);
      b.data = bus.wdata;
      b.strb = bus.wstrb;
      b.last = (cur_idx == cur_len);
      if (lastbit != b.last) cur_err = 1'b1;
      exp_q.push_back(b);
      cur_idx++;
    end
    @(negedge clk);
    bus.wvalid = 1'b0;
  endtask

  task automatic wait_b(input int hold);
    logic [1:0] er;
    er = cur_err ? 2'b10 : 2'b00;
    check("bvalid_latency", 64'(bus.bvalid), 64'd1);
    check("bid", 64'(bus.bid), 64'(cur_id));
    check("bresp", 64'(bus.bresp), 64'(er));
    check("wready_in_resp", 64'(bus.wready), 64'd0);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("bvalid_hold", 64'(bus.bvalid), 64'd1);
      check("bid_hold", 64'(bus.bid), 64'(cur_id));
      check("bresp_hold", 64'(bus.bresp), 64'(er));
      check("awready_hold", 64'(bus.awready), 64'd0);
    end
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
    check("bvalid_clear", 64'(bus.bvalid), 64'd0);
    check("awready_after_b", 64'(bus.awready), 64'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.cvalid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain_model_empty", 64'(exp_q.size()), 64'd0);
    check("drain_fill", 64'(fill_lvl), 64'd0);
    check("drain_cvalid", 64'(bus.cvalid), 64'd0);
  endtask

  initial begin
    int d0;
    int wl_at;
    int len;
    bus.awvalid = 1'b0; bus.awid = '0; bus.awaddr = '0; bus.awlen = 4'd0;
    bus.wvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0;
    bus.bready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values.
    check("rst_awready", 64'(bus.awready), 64'd1);
    check("rst_wready", 64'(bus.wready), 64'd0);
    check("rst_bvalid", 64'(bus.bvalid), 64'd0);
    check("rst_bid", 64'(bus.bid), 64'd0);
    check("rst_bresp", 64'(bus.bresp), 64'd0);
    check("rst_cvalid", 64'(bus.cvalid), 64'd0);
    check("rst_fill", 64'(fill_lvl), 64'd0);
    check("rst_caddr", 64'(bus.caddr), 64'd0);
    check("rst_cdata", 64'(bus.cdata), 64'd0);
    check("rst_clast", 64'(bus.clast), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // W traffic while idle is ignored.
    bus.wvalid = 1'b1; bus.wlast = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_wready", 64'(bus.wready), 64'd0);
    check("idle_fill", 64'(fill_lvl), 64'd0);
    bus.wvalid = 1'b0; bus.wlast = 1'b0;

    // Four-beat burst at 0x1000 with a correct wlast.
    cready_mode = 1;
    d0 = delivered;
    do_aw(4'h5, 32'h0000_1000, 3);
    send_beat(1'b0);
    check("first_beat_cvalid", 64'(bus.cvalid), 64'd1);
    check("first_beat_caddr", 64'(bus.caddr), 64'h1000);
    send_beat(1'b0);
    send_beat(1'b0);
    send_beat(1'b1);
    check("good_bresp", 64'(bus.bresp), 64'(BRESP_OKAY));
    wait_b(0);
    drain();
    check("good_count", 64'(delivered - d0), 64'd4);

    // Early wlast: both beats still taken, response is SLVERR.
    d0 = delivered;
    do_aw(4'h2, 32'h0000_2000, 1);
    send_beat(1'b1);
    send_beat(1'b0);
    check("early_last_bresp", 64'(bus.bresp), 64'(BRESP_SLVERR));
    wait_b(0);
    drain();
    check("early_last_count", 64'(delivered - d0), 64'd2);

    // Backpressure: sixteen-beat burst with the consumer stalled.
    cready_mode = 0;
    d0 = delivered;
    do_aw(4'h7, 32'h0000_4000, 15);
    for (int i = 0; i < 8; i++) send_beat(1'b0);
    repeat (2) @(negedge clk);
    check("full_fill", 64'(fill_lvl), 64'd8);
    check("full_wready", 64'(bus.wready), 64'd0);
    cready_mode = 1;
    for (int i = 8; i < 16; i++) send_beat(i == 15);
    wait_b(0);
    drain();
    check("full_count", 64'(delivered - d0), 64'd16);

    // Address wrap at the top of the address space; B comes before draining.
    cready_mode = 0;
    do_aw(4'h1, 32'hFFFF_FFF8, 1);
    send_beat(1'b0);
    send_beat(1'b1);
    check("wrap_head_caddr", 64'(bus.caddr), 64'hFFFF_FFF8);
    check("wrap_fill", 64'(fill_lvl), 64'd2);
    wait_b(0);
    cready_mode = 1;
    drain();

    // Reset in the middle of a burst discards everything.
    cready_mode = 0;
    do_aw(4'h3, 32'h0000_3000, 3);
    send_beat(1'b0);
    send_beat(1'b0);
    check("pre_rst_fill", 64'(fill_lvl), 64'd2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_fill", 64'(fill_lvl), 64'd0);
    check("mid_rst_cvalid", 64'(bus.cvalid), 64'd0);
    check("mid_rst_bvalid", 64'(bus.bvalid), 64'd0);
    check("mid_rst_awready", 64'(bus.awready), 64'd1);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_bvalid", 64'(bus.bvalid), 64'd0);
    end
    cready_mode = 1;
    d0 = delivered;
    do_aw(4'h4, 32'h0000_3000, 3);
    for (int i = 0; i < 4; i++) send_beat(i == 3);
    wait_b(0);
    drain();
    check("post_rst_count", 64'(delivered - d0), 64'd4);

    // Held-off B response stays stable; AW ignored during the data phase.
    do_aw(4'h9, 32'h0000_5000, 0);
    bus.awvalid = 1'b1; bus.awaddr = 32'h0000_7770; bus.awid = 4'hE;
    repeat (2) @(negedge clk);
    send_beat(1'b1);
    bus.awvalid = 1'b0;
    wait_b(5);
    drain();

    // Randomized bursts with random consumer backpressure.
    for (int r = 0; r < 8; r++) begin
      cready_mode = 2;
      len = $urandom_range(0, 15);
      wl_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : len;
      do_aw(ID_W'($urandom), ADDR_W'($urandom) & 32'hFFFF_FFF8, len);
      for (int i = 0; i <= len; i++) begin
        send_beat(i == wl_at);
        if ($urandom_range(0, 2) == 0) @(negedge clk);
      end
      wait_b($urandom_range(0, 3));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
